sd_cmd_framer: RTL and testbench

//  Upstream command sequencer for the soft SPI byte engine on the SD-card path.
//  CPU writes argument and command index over Avalon-MM; the block frames the
//  6-byte SD command (start/index, arg, CRC7|stop) and issues it byte-by-byte.
//  It then polls for the R1 response and reports R1, done and timeout status.

---
 rtl/sd_cmd_framer_pkg.sv | 40 ++++
 rtl/sd_cmd_framer_if.sv | 28 ++
 rtl/sd_cmd_framer.sv | 202 ++++++++++++++++++++
 tb/tb_sd_cmd_framer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_framer_pkg.sv
// Shared types and constants for the SD command framer: FSM states, register
// map positions and the CRC7 used to seal each 6-byte command frame.
package sd_cmd_framer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    POLL = 2'd2
  } state_e;

  localparam logic [6:0] CRC7_POLY  = 7'h09;  // x^7 + x^3 + 1, x^7 implicit
  localparam logic [1:0] START_BITS = 2'b01;

  localparam logic [1:0] ADDR_ARG = 2'd0;
  localparam logic [1:0] ADDR_CMD = 2'd1;
  localparam logic [1:0] ADDR_R1  = 2'd2;

  localparam int CMD_GO_BIT       = 8;
  localparam int STAT_BUSY_BIT    = 10;
  localparam int STAT_TIMEOUT_BIT = 9;
  localparam int STAT_DONE_BIT    = 8;

  // Shift one byte MSB-first through the CRC7 register.
  function automatic logic [6:0] crc7_update(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ CRC7_POLY;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_cmd_framer_if.sv
// Avalon-MM register port plus SPI byte-engine handshake of the SD command framer.
interface sd_cmd_framer_if;
  logic [1:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic [31:0] avs_s0_readdata;
  logic        avs_s0_waitrequest;
  logic        spi_req;
  logic        spi_rd;
  logic [7:0]  spi_wdata;
  logic        spi_ack;
  logic [7:0]  spi_rdata;

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  spi_ack, spi_rdata,
    output avs_s0_readdata, avs_s0_waitrequest,
    output spi_req, spi_rd, spi_wdata
  );

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output spi_ack, spi_rdata,
    input  avs_s0_readdata, avs_s0_waitrequest,
    input  spi_req, spi_rd, spi_wdata
  );
endinterface

// File: rtl/sd_cmd_framer.sv
// Frames a 6-byte SD command from CPU-written index/argument, issues it byte by
// byte to the SPI engine, then polls for R1 and reports done/timeout status.
module sd_cmd_framer
  import sd_cmd_framer_pkg::*;
#(
  parameter int POLL_MAX = 8
) (
  input logic            clk,
  input logic            reset,
  sd_cmd_framer_if.slave bus
);

  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

  state_e      state_q, state_d;
  logic [31:0] arg_q, arg_d;
  logic [5:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  r1_q, r1_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [6:0]  crc_q, crc_d;
  logic        spi_req_q, spi_req_d;
  logic        spi_rd_q, spi_rd_d;
  logic [7:0]  spi_wdata_q, spi_wdata_d;

  logic        start_s, arg_wr_s, stat_rd_s, ack_s;
  logic [7:0]  frame_byte_s;
  logic [31:0] status_s;

  assign start_s   = bus.avs_s0_write && (bus.avs_s0_address == ADDR_CMD)
                     && bus.avs_s0_writedata[CMD_GO_BIT] && !busy_q;
  assign arg_wr_s  = bus.avs_s0_write && (bus.avs_s0_address == ADDR_ARG) && !busy_q;
  assign stat_rd_s = bus.avs_s0_read && (bus.avs_s0_address == ADDR_CMD);
  // A stray ack with no request outstanding must not advance anything.
  assign ack_s     = bus.spi_ack && spi_req_q;

  // Byte k of the frame; byte 5 uses the CRC accumulated over bytes 0..4.
  always_comb begin
    case (byte_cnt_q)
      3'd0:    frame_byte_s = {START_BITS, idx_q};
      3'd1:    frame_byte_s = arg_q[31:24];
      3'd2:    frame_byte_s = arg_q[23:16];
      3'd3:    frame_byte_s = arg_q[15:8];
      3'd4:    frame_byte_s = arg_q[7:0];
      3'd5:    frame_byte_s = {crc_q, 1'b1};
      default: frame_byte_s = 8'hFF;
    endcase
  end

  // Status word and read-data mux.
  always_comb begin
    status_s                   = {24'd0, r1_q};
    status_s[STAT_BUSY_BIT]    = busy_q;
    status_s[STAT_TIMEOUT_BIT] = timeout_q;
    status_s[STAT_DONE_BIT]    = done_q;
    case (bus.avs_s0_address)
      ADDR_ARG: bus.avs_s0_readdata = arg_q;
      ADDR_CMD: bus.avs_s0_readdata = status_s;
      ADDR_R1:  bus.avs_s0_readdata = {24'd0, r1_q};
      default:  bus.avs_s0_readdata = 32'd0;
    endcase
  end

  assign bus.avs_s0_waitrequest = 1'b0;
  assign bus.spi_req            = spi_req_q;
  assign bus.spi_rd             = spi_rd_q;
  assign bus.spi_wdata          = spi_wdata_q;

  // Next-state logic for the sequencer, counters and register file.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    timeout_d   = timeout_q;
    r1_d        = r1_q;
    byte_cnt_d  = byte_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    crc_d       = crc_q;
    spi_req_d   = spi_req_q;
    spi_rd_d    = spi_rd_q;
    spi_wdata_d = spi_wdata_q;

    if (arg_wr_s) begin
      arg_d = bus.avs_s0_writedata;
    end else begin
      arg_d = arg_q;
    end

    // Any later set in the same cycle overrides this clear.
    if (stat_rd_s) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end

    case (state_q)
      IDLE: begin
        if (start_s) begin
          idx_d       = bus.avs_s0_writedata[5:0];
          busy_d      = 1'b1;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          crc_d       = 7'd0;
          byte_cnt_d  = 3'd0;
          spi_req_d   = 1'b1;
          spi_rd_d    = 1'b0;
          spi_wdata_d = {START_BITS, bus.avs_s0_writedata[5:0]};
          state_d     = SEND;
        end else begin
          spi_req_d = 1'b0;
        end
      end
      SEND: begin
        if (ack_s) begin
          spi_req_d = 1'b0;
          if (byte_cnt_q == 3'd5) begin
            poll_cnt_d = 8'd0;
            state_d    = POLL;
          end else begin
            crc_d      = crc7_update(crc_q, spi_wdata_q);
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else if (!spi_req_q) begin
          spi_req_d   = 1'b1;
          spi_rd_d    = 1'b0;
          spi_wdata_d = frame_byte_s;
        end else begin
          spi_req_d = 1'b1;
        end
      end
      POLL: begin
        if (ack_s) begin
          spi_req_d = 1'b0;
          if (!bus.spi_rdata[7]) begin
            r1_d     = bus.spi_rdata;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            spi_rd_d = 1'b0;
            state_d  = IDLE;
          end else if (poll_cnt_q == POLL_LAST) begin
            r1_d      = 8'hFF;
            timeout_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            spi_rd_d  = 1'b0;
            state_d   = IDLE;
          end else begin
            poll_cnt_d = poll_cnt_q + 8'd1;
          end
        end else if (!spi_req_q) begin
          spi_req_d   = 1'b1;
          spi_rd_d    = 1'b1;
          spi_wdata_d = 8'hFF;
        end else begin
          spi_req_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        spi_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      arg_q       <= 32'd0;
      idx_q       <= 6'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      r1_q        <= 8'hFF;
      byte_cnt_q  <= 3'd0;
      poll_cnt_q  <= 8'd0;
      crc_q       <= 7'd0;
      spi_req_q   <= 1'b0;
      spi_rd_q    <= 1'b0;
      spi_wdata_q <= 8'hFF;
    end else begin
      state_q     <= state_d;
      arg_q       <= arg_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      r1_q        <= r1_d;
      byte_cnt_q  <= byte_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      crc_q       <= crc_d;
      spi_req_q   <= spi_req_d;
      spi_rd_q    <= spi_rd_d;
      spi_wdata_q <= spi_wdata_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Self-checking bench for sd_cmd_framer: directed and random commands against a
// frame/CRC model built from polynomial division, with an SPI engine responder.
module tb_sd_cmd_framer;

  localparam int POLL_MAX = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [7:0] cap_bytes [6];

  sd_cmd_framer_if bus ();

  sd_cmd_framer #(.POLL_MAX(POLL_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [7:0] ref_byte(input logic [5:0] idx, input logic [31:0] arg, input int k);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    if (k == 5) return {ref_crc7(msg), 1'b1};
    return msg[39 - 8*k -: 8];
  endfunction

  function automatic logic [31:0] ref_status(input logic busy, input logic tmo, input logic done, input logic [7:0] r1);
    return {21'd0, busy, tmo, done, r1};
  endfunction

  // Both Avalon tasks are entered just after a falling edge.
  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    bus.avs_s0_address   = a;
    bus.avs_s0_writedata = d;
    bus.avs_s0_write     = 1'b1;
    @(negedge clk);
    bus.avs_s0_write     = 1'b0;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    bus.avs_s0_address = a;
    bus.avs_s0_read    = 1'b1;
    #1 d = bus.avs_s0_readdata;
    @(negedge clk);
    bus.avs_s0_read    = 1'b0;
  endtask

  task automatic reset_mid_frame(input string tag);
    logic [31:0] rd;
    logic        bad;
    #2 reset = 1'b1;
    #1 chk({tag, "_req_async"}, {63'd0, bus.spi_req}, 64'd0);
    chk({tag, "_spi_outs"}, {54'd0, bus.spi_rd, bus.spi_wdata}, {54'd0, 1'b0, 8'hFF});
    @(negedge clk);
    av_read(2'd1, rd);
    chk({tag, "_status"}, {32'd0, rd}, {32'd0, ref_status(1'b0, 1'b0, 1'b0, 8'hFF)});
    av_read(2'd0, rd);
    chk({tag, "_arg"}, {32'd0, rd}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    bus.spi_rdata = 8'h00;
    bus.spi_ack   = 1'b1;
    @(negedge clk);
    bus.spi_ack   = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.spi_req) bad = 1'b1;
    end
    chk({tag, "_stray_ack_req"}, {63'd0, bad}, 64'd0);
    av_read(2'd1, rd);
    chk({tag, "_stray_status"}, {32'd0, rd}, {32'd0, ref_status(1'b0, 1'b0, 1'b0, 8'hFF)});
  endtask

  // mode 0: plain, 1: ARG/start writes while busy, 2: status read on final ack,
  // 3: reset during byte 3.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int n_ff,
                         input logic [7:0] r1v, input int mode, input string tag);
    int          exp_polls, total, n_xfer, w, dly;
    logic        exp_to, stop;
    logic [7:0]  exp_r1, wd;
    logic [31:0] rd;
    exp_to    = (n_ff >= POLL_MAX);
    exp_polls = exp_to ? POLL_MAX : n_ff + 1;
    exp_r1    = exp_to ? 8'hFF : r1v;
    total     = 6 + exp_polls;

    av_write(2'd0, arg);
    av_write(2'd1, {23'd0, 1'b1, 2'b00, idx});
    chk({tag, "_req_latency"}, {63'd0, bus.spi_req}, 64'd1);

    n_xfer = 0;
    stop   = 1'b0;
    while (!stop && n_xfer < total + 2) begin
      w = 0;
      while (!bus.spi_req && w < 16) begin
        @(negedge clk);
        w++;
      end
      if (!bus.spi_req) begin
        stop = 1'b1;
      end else begin
        wd = bus.spi_wdata;
        if (n_xfer < 6) begin
          cap_bytes[n_xfer] = wd;
          chk({tag, "_send_rd"}, {63'd0, bus.spi_rd}, 64'd0);
          chk({tag, "_byte"}, {56'd0, wd}, {56'd0, ref_byte(idx, arg, n_xfer)});
        end else begin
          chk({tag, "_poll_rd"}, {55'd0, bus.spi_rd, wd}, {55'd0, 1'b1, 8'hFF});
        end
        if (mode == 3 && n_xfer == 3) begin
          reset_mid_frame(tag);
          return;
        end
        if (mode == 1 && n_xfer == 1) begin
          av_write(2'd0, ~arg);
          av_write(2'd1, {23'd0, 1'b1, 2'b00, ~idx});
          av_read(2'd1, rd);
          chk({tag, "_busy_bit"}, {63'd0, rd[10]}, 64'd1);
        end
        dly = int'($urandom_range(2, 0));
        repeat (dly) @(negedge clk);
        chk({tag, "_req_hold"}, {55'd0, bus.spi_req, bus.spi_wdata}, {55'd0, 1'b1, wd});
        if (n_xfer < 6) begin
          bus.spi_rdata = 8'($urandom);
        end else if (n_xfer - 6 < n_ff) begin
          bus.spi_rdata = 8'h80 | 8'($urandom);
        end else begin
          bus.spi_rdata = r1v;
        end
        bus.spi_ack = 1'b1;
        if (mode == 2 && n_xfer == total - 1) begin
          bus.avs_s0_address = 2'd1;
          bus.avs_s0_read    = 1'b1;
          #1 rd = bus.avs_s0_readdata;
          chk({tag, "_same_cycle_read"}, {61'd0, rd[10:8]}, {61'd0, 3'b100});
        end
        @(negedge clk);
        bus.spi_ack     = 1'b0;
        bus.avs_s0_read = 1'b0;
        chk({tag, "_req_drop"}, {63'd0, bus.spi_req}, 64'd0);
        n_xfer++;
        if (n_xfer == total && mode != 2) begin
          av_read(2'd1, rd);
          chk({tag, "_done_status"}, {32'd0, rd}, {32'd0, ref_status(1'b0, exp_to, 1'b1, exp_r1)});
        end
      end
    end
    chk({tag, "_xfer_count"}, 64'(n_xfer), 64'(total));
    if (mode == 2) begin
      av_read(2'd1, rd);
      chk({tag, "_done_kept"}, {32'd0, rd}, {32'd0, ref_status(1'b0, exp_to, 1'b1, exp_r1)});
    end
    av_read(2'd1, rd);
    chk({tag, "_done_cleared"}, {32'd0, rd}, {32'd0, ref_status(1'b0, exp_to, 1'b0, exp_r1)});
    av_read(2'd2, rd);
    chk({tag, "_r1"}, {32'd0, rd}, {56'd0, exp_r1});
    av_read(2'd0, rd);
    chk({tag, "_arg_kept"}, {32'd0, rd}, {32'd0, arg});
  endtask

  initial begin
    logic [31:0] rd;
    reset                = 1'b1;
    bus.avs_s0_address   = 2'd0;
    bus.avs_s0_read      = 1'b0;
    bus.avs_s0_write     = 1'b0;
    bus.avs_s0_writedata = 32'd0;
    bus.spi_ack          = 1'b0;
    bus.spi_rdata        = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("reset_spi", {54'd0, bus.spi_req, bus.spi_rd, bus.spi_wdata}, {54'd0, 2'b00, 8'hFF});
    chk("reset_waitreq", {63'd0, bus.avs_s0_waitrequest}, 64'd0);
    av_read(2'd1, rd);
    chk("reset_status", {32'd0, rd}, {32'd0, ref_status(1'b0, 1'b0, 1'b0, 8'hFF)});
    av_read(2'd2, rd);
    chk("reset_r1", {32'd0, rd}, 64'h00000000000000FF);
    av_read(2'd0, rd);
    chk("reset_arg", {32'd0, rd}, 64'd0);
    av_read(2'd3, rd);
    chk("addr3_zero", {32'd0, rd}, 64'd0);

    run_cmd(6'd0, 32'd0, 2, 8'h01, 0, "cmd0");
    chk("cmd0_frame", {16'd0, cap_bytes[0], cap_bytes[1], cap_bytes[2], cap_bytes[3],
        cap_bytes[4], cap_bytes[5]}, 64'h0000_4000_0000_0095);

    run_cmd(6'd8, 32'h0000_01AA, 0, 8'h01, 0, "cmd8");
    chk("cmd8_frame", {16'd0, cap_bytes[0], cap_bytes[1], cap_bytes[2], cap_bytes[3],
        cap_bytes[4], cap_bytes[5]}, 64'h0000_4800_0001_AA87);

    av_write(2'd2, 32'h0000_0055);
    av_write(2'd3, 32'h0000_0155);
    av_read(2'd2, rd);
    chk("r1_write_ignored", {32'd0, rd}, 64'h0000000000000001);

    run_cmd(6'd55, 32'h0BAD_F00D, 8, 8'h00, 0, "timeout");
    run_cmd(6'd17, 32'hDEAD_BEEF, 1, 8'h05, 1, "busy_ign");
    run_cmd(6'd12, 32'h1234_5678, 2, 8'h00, 2, "rd_same");
    run_cmd(6'd2, 32'hCAFE_F00D, 0, 8'h01, 3, "rst_mid");

    for (int t = 0; t < 6; t++) begin
      run_cmd(6'($urandom), $urandom, int'($urandom_range(9, 0)), 8'($urandom_range(127, 0)), 0,
              $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
